// File: rtl/adder_nbit_serial.sv
// Multi-cycle adder: sum = a + b + cin, processed CHUNK bits per cycle, LSB chunk first,
// with operands and results exchanged on valid/ready handshakes.
module adder_nbit_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_param_check
    $fatal(1, "adder_nbit_serial: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chain_cout;
  logic             msb_cin;

  // Ripple chain of CHUNK full-adder slices over the low bits of the operand shifters.
  always_comb begin
    logic c;
    c         = carry_q;
    chunk_sum = '0;
    msb_cin   = 1'b0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      msb_cin      = c;
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    chain_cout = c;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        // Result bits enter from the MSB side so the LSB chunk ends up at bit 0.
        acc_d   = WIDTH'({chunk_sum, acc_q} >> CHUNK);
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chain_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(NCHUNK - 1)) begin
          sum_d       = {chain_cout, acc_d};
          ovf_d       = msb_cin ^ chain_cout;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_nbit_serial.sv
// Directed bench for adder_nbit_serial: 8/2 instance for scenarios, 4/1 and 4/4 for sweeps.
module tb_adder_nbit_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       cin = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       in_ready, out_valid, ovf;
  logic [8:0] sum;

  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       iv4 = 1'b0;
  logic       or4 = 1'b1;
  logic       sel4 = 1'b0;
  logic       ir_c1, ov_c1, of_c1, ir_c4, ov_c4, of_c4;
  logic [4:0] s_c1, s_c4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_nbit_serial #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  adder_nbit_serial #(.WIDTH(4), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .in_valid(iv4 & ~sel4), .in_ready(ir_c1), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov_c1), .out_ready(or4), .sum(s_c1), .ovf(of_c1)
  );

  adder_nbit_serial #(.WIDTH(4), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(iv4 & sel4), .in_ready(ir_c4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov_c4), .out_ready(or4), .sum(s_c4), .ovf(of_c4)
  );

  // Drives one operation into the 8-bit instance and returns the first valid result.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       output logic [8:0] s, output logic o, output int lat);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum; o = ovf;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 9'h000) begin errors++; $display("FAIL reset_sum: got %h want 000", sum); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [8:0] s; logic o; int lat;
    out_ready = 1'b1;
    do_op(8'h0F, 8'h01, 1'b0, s, o, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (s !== 9'h010) begin errors++; $display("FAIL basic_sum: got %h want 010", s); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", o); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_carry_ripple();
    logic [8:0] s; logic o; int lat;
    do_op(8'hFF, 8'hFF, 1'b1, s, o, lat);
    checks++; if (s !== 9'h1FF) begin errors++; $display("FAIL ripple_ff_sum: got %h want 1FF", s); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL ripple_ff_ovf: got %b want 0", o); end
    drain();
    do_op(8'hFF, 8'h00, 1'b1, s, o, lat);
    checks++; if (s !== 9'h100) begin errors++; $display("FAIL ripple_cin_sum: got %h want 100", s); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL ripple_cin_ovf: got %b want 0", o); end
    drain();
  endtask

  task automatic test_overflow();
    logic [8:0] s; logic o; int lat;
    do_op(8'h7F, 8'h01, 1'b0, s, o, lat);
    checks++; if (s !== 9'h080) begin errors++; $display("FAIL ovf_pos_sum: got %h want 080", s); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_pos_flag: got %b want 1", o); end
    drain();
    do_op(8'h80, 8'h80, 1'b0, s, o, lat);
    checks++; if (s !== 9'h100) begin errors++; $display("FAIL ovf_neg_sum: got %h want 100", s); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_neg_flag: got %b want 1", o); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [8:0] s; logic o; int lat;
    out_ready = 1'b0;
    do_op(8'h3C, 8'h21, 1'b1, s, o, lat);
    checks++; if (s !== 9'h05E) begin errors++; $display("FAIL bp_sum: got %h want 05E", s); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'(i * 17); b = 8'(i + 3); cin = 1'b1;
      @(posedge clk); #1;
      checks++; if (sum !== 9'h05E) begin errors++; $display("FAIL bp_hold_sum: got %h want 05E", sum); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_hold_ovf: got %b want 0", ovf); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 9'h05E) begin errors++; $display("FAIL bp_release_sum: got %h want 05E", sum); end
    do_op(8'h55, 8'hAA, 1'b0, s, o, lat);
    checks++; if (s !== 9'h0FF) begin errors++; $display("FAIL bp_next_sum: got %h want 0FF", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_next_latency: got %0d want 4", lat); end
    drain();
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] s; logic o; int lat;
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hF0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    checks++; if (sum !== 9'h000) begin errors++; $display("FAIL rst_mid_sum: got %h want 000", sum); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid: got %b want 0", out_valid); end
    do_op(8'h12, 8'h34, 1'b0, s, o, lat);
    checks++; if (s !== 9'h046) begin errors++; $display("FAIL rst_next_sum: got %h want 046", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rst_next_latency: got %0d want 4", lat); end
    drain();
  endtask

  task automatic test_sweep(input logic use4);
    logic [4:0] exp_s, got_s;
    logic       exp_o, got_o;
    int         exp_lat, lat, wc;
    sel4 = use4;
    exp_lat = use4 ? 1 : 4;
    for (int v = 0; v < 512; v++) begin
      wc = 0;
      while (!(use4 ? ir_c4 : ir_c1) && wc < 20) begin
        or4 = 1'b1;
        @(posedge clk); #1;
        wc++;
      end
      a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
      or4 = 1'($urandom_range(0, 1));
      iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0; a4 = ~a4; b4 = ~b4; cin4 = ~cin4;
      lat = 0;
      while (!(use4 ? ov_c4 : ov_c1) && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      got_s = use4 ? s_c4 : s_c1;
      got_o = use4 ? of_c4 : of_c1;
      exp_s = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
      exp_o = (v[8] == v[4]) && (exp_s[3] != v[8]);
      checks++; if (got_s !== exp_s) begin errors++; $display("FAIL sweep%0d_sum v=%0d: got %h want %h", exp_lat, v, got_s, exp_s); end
      checks++; if (got_o !== exp_o) begin errors++; $display("FAIL sweep%0d_ovf v=%0d: got %b want %b", exp_lat, v, got_o, exp_o); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sweep%0d_latency v=%0d: got %0d want %0d", exp_lat, v, lat, exp_lat); end
      wc = 0;
      while ((use4 ? ov_c4 : ov_c1) && wc < 20) begin
        or4 = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        wc++;
      end
    end
    or4 = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_sweep(1'b0);
    test_sweep(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
